// File: rtl/lenet_pkg.sv
// Purpose : shared LeNet constants (data width, BRAM address widths, layer base addresses, fc_2 FSM encoding).
// Latency : n/a (constants and types only).
// Backpres: n/a.
package lenet_pkg;

   localparam int DATA_SIZE = 8;

   // Address widths of the two shared BRAMs.
   localparam int BW_AW  = 19;   // bias/weights BRAM
   localparam int RES_AW = 15;   // result BRAM

   // fc_2 layer placement inside the shared BRAMs.
   localparam int FC2_IN_BASE  = 18400;    // result BRAM: fc_1 activation 0
   localparam int FC2_W_BASE   = 431070;   // bias/weights BRAM: weight[0][0]
   localparam int FC2_B_BASE   = 436070;   // bias/weights BRAM: bias 0
   localparam int FC2_OUT_BASE = 18900;    // result BRAM: class score 0

   // fc_2 FSM encoding.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_BIAS   = 3'd1;
   localparam logic [2:0] ST_MAC    = 3'd2;
   localparam logic [2:0] ST_STORE  = 3'd3;
   localparam logic [2:0] ST_NEXT   = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;
   localparam logic [2:0] ST_ARGMAX = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_BIAS   = ST_BIAS,
      S_MAC    = ST_MAC,
      S_STORE  = ST_STORE,
      S_NEXT   = ST_NEXT,
      S_DONE   = ST_DONE,
      S_ARGMAX = ST_ARGMAX
   } fc2_state_t;

endpackage

// File: rtl/fc_2_mac_sat.sv
// Purpose : signed DW x DW multiply-accumulate register with bias load, plus shift-and-saturate to DW bits.
// Latency : acc updates on the edge where load/mac is high; sat_q is combinational from acc.
// Backpres: none; the caller strobes load/mac exactly once per captured operand.
// Ports   : clk, rst (async active-low), clr/load/mac controls, a (weight or bias), b (activation), sat_q (score).
module mac_sat #(
   parameter int DW        = 8,
   parameter int ACC_W     = 24,
   parameter int FRAC_BITS = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          load,
   input  logic          mac,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] sat_q
);

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (DW - 1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  sh;
   logic signed [DW-1:0]     a_s;
   logic signed [DW-1:0]     b_s;
   logic signed [2*DW-1:0]   prod;

   assign a_s  = $signed(a);
   assign b_s  = $signed(b);
   assign prod = a_s * b_s;

   // load places the bias at the same binary point as the weight*activation products.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (load) begin
         acc <= ACC_W'(a_s) <<< FRAC_BITS;
      end else if (mac) begin
         acc <= acc + ACC_W'(prod);
      end
   end

   assign sh = acc >>> FRAC_BITS;

   always_comb begin
      sat_q = sh[DW-1:0];
      if (sh > SAT_HI) begin
         sat_q = {1'b0, {(DW-1){1'b1}}};
      end else if (sh < SAT_LO) begin
         sat_q = {1'b1, {(DW-1){1'b0}}};
      end
   end

endmodule

// File: rtl/fc_2.sv
// Purpose : LeNet final fully-connected layer; N_OUT serial dot products of N_IN fc_1 activations, no ReLU.
// Latency : (N_IN+1)*(RD_LAT+1)+2 cycles per neuron, N_OUT neurons, +1 cycle into S_DONE (+1 more with argmax).
// Backpres: none; fc_2_en is a level run request, dropping it before S_DONE aborts the layer without a write.
// Ports   : clk, rst (async active-low), fc_2_en, two BRAM read ports (douta), bias/weights BRAM ena/addra,
//           result BRAM ena/wea/addra/dina, fc_2_finish, class_id.
// Option  : define FC2_ARGMAX_EN to track the argmax score and write its index to OUT_BASE+N_OUT.
module fc_2 #(
   parameter int N_IN      = 500,
   parameter int N_OUT     = 10,
   parameter int DATA_SIZE = lenet_pkg::DATA_SIZE,
   parameter int ACC_W     = 24,
   parameter int FRAC_BITS = 6,
   parameter int RD_LAT    = 2,
   parameter int IN_BASE   = lenet_pkg::FC2_IN_BASE,
   parameter int W_BASE    = lenet_pkg::FC2_W_BASE,
   parameter int B_BASE    = lenet_pkg::FC2_B_BASE,
   parameter int OUT_BASE  = lenet_pkg::FC2_OUT_BASE
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fc_2_en,
   input  logic [DATA_SIZE-1:0]         bias_weights_bram_douta,
   input  logic [DATA_SIZE-1:0]         result_bram_douta,
   output logic                         bias_weights_bram_ena,
   output logic [lenet_pkg::BW_AW-1:0]  bias_weights_bram_addra,
   output logic                         result_bram_ena,
   output logic                         result_bram_wea,
   output logic [lenet_pkg::RES_AW-1:0] result_bram_addra,
   output logic [DATA_SIZE-1:0]         result_bram_dina,
   output logic                         fc_2_finish,
   output logic [3:0]                   class_id
);

   import lenet_pkg::*;

   localparam int               I_W      = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int               O_W      = $clog2(N_OUT + 1);
   localparam logic [1:0]       LAST_CNT = 2'(RD_LAT);
   localparam logic [I_W-1:0]   LAST_I   = I_W'(N_IN - 1);
   localparam logic [O_W-1:0]   LAST_O   = O_W'(N_OUT - 1);

   fc2_state_t             state;
   logic [O_W-1:0]         o;
   logic [I_W-1:0]         i;
   logic [1:0]             cnt;
   logic [BW_AW-1:0]       w_ptr;
   logic                   slot_end;
   logic                   acc_clr;
   logic                   acc_load;
   logic                   acc_mac;
   logic [DATA_SIZE-1:0]   score;

`ifdef FC2_ARGMAX_EN
   logic signed [DATA_SIZE-1:0] max_score;
   logic [3:0]                  best_id;
   assign class_id = best_id;
`else
   assign class_id = 4'd0;
`endif

   // A slot is RD_LAT+1 cycles: address out in cycle 0, data usable in cycle RD_LAT.
   assign slot_end = (cnt == LAST_CNT);
   assign acc_clr  = (state == S_IDLE) && fc_2_en;
   assign acc_load = (state == S_BIAS) && slot_end && fc_2_en;
   assign acc_mac  = (state == S_MAC)  && slot_end && fc_2_en;

   mac_sat #(
      .DW        (DATA_SIZE),
      .ACC_W     (ACC_W),
      .FRAC_BITS (FRAC_BITS)
   ) u_mac_sat (
      .clk   (clk),
      .rst   (rst),
      .clr   (acc_clr),
      .load  (acc_load),
      .mac   (acc_mac),
      .a     (bias_weights_bram_douta),
      .b     (result_bram_douta),
      .sat_q (score)
   );

   // Write data is only meaningful while wea is high; held at zero otherwise.
   always_comb begin
      result_bram_dina = '0;
      if (result_bram_wea) begin
         result_bram_dina = score;
`ifdef FC2_ARGMAX_EN
         if (state == S_ARGMAX) begin
            result_bram_dina = DATA_SIZE'(best_id);
         end
`endif
      end
   end

   // Weight rows are contiguous, so W_BASE + o*N_IN + i is a single pointer that
   // advances by one per MAC slot for the whole run; no multiplier needed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                   <= S_IDLE;
         o                       <= '0;
         i                       <= '0;
         cnt                     <= '0;
         w_ptr                   <= '0;
         bias_weights_bram_ena   <= 1'b0;
         bias_weights_bram_addra <= '0;
         result_bram_ena         <= 1'b0;
         result_bram_wea         <= 1'b0;
         result_bram_addra       <= '0;
         fc_2_finish             <= 1'b0;
`ifdef FC2_ARGMAX_EN
         max_score               <= '0;
         best_id                 <= '0;
`endif
      end else if (!fc_2_en && state != S_IDLE && state != S_DONE) begin
         // Abort: drop every strobe on this edge so no partial result is written.
         state                   <= S_IDLE;
         o                       <= '0;
         i                       <= '0;
         cnt                     <= '0;
         bias_weights_bram_ena   <= 1'b0;
         bias_weights_bram_addra <= '0;
         result_bram_ena         <= 1'b0;
         result_bram_wea         <= 1'b0;
         result_bram_addra       <= '0;
         fc_2_finish             <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (fc_2_en) begin
                  state                   <= S_BIAS;
                  o                       <= '0;
                  i                       <= '0;
                  cnt                     <= '0;
                  w_ptr                   <= BW_AW'(W_BASE);
                  bias_weights_bram_ena   <= 1'b1;
                  bias_weights_bram_addra <= BW_AW'(B_BASE);
`ifdef FC2_ARGMAX_EN
                  max_score               <= '0;
                  best_id                 <= '0;
`endif
               end
            end

            S_BIAS: begin
               if (slot_end) begin
                  state                   <= S_MAC;
                  cnt                     <= '0;
                  bias_weights_bram_addra <= w_ptr;
                  result_bram_ena         <= 1'b1;
                  result_bram_addra       <= RES_AW'(IN_BASE);
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end

            S_MAC: begin
               if (slot_end) begin
                  cnt   <= '0;
                  w_ptr <= w_ptr + 1'b1;
                  if (i == LAST_I) begin
                     // Read port stays enabled and becomes the write port for S_STORE.
                     state                 <= S_STORE;
                     bias_weights_bram_ena <= 1'b0;
                     result_bram_wea       <= 1'b1;
                     result_bram_addra     <= RES_AW'(OUT_BASE + int'(o));
                  end else begin
                     i                       <= i + 1'b1;
                     bias_weights_bram_addra <= w_ptr + 1'b1;
                     result_bram_addra       <= RES_AW'(IN_BASE + int'(i) + 1);
                  end
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end

            S_STORE: begin
               state           <= S_NEXT;
               result_bram_ena <= 1'b0;
               result_bram_wea <= 1'b0;
`ifdef FC2_ARGMAX_EN
               // Strictly greater wins, so a tie keeps the earlier (lower) index.
               if (o == '0 || $signed(score) > max_score) begin
                  max_score <= $signed(score);
                  best_id   <= 4'(o);
               end
`endif
            end

            S_NEXT: begin
               i <= '0;
               o <= o + 1'b1;
               if (o == LAST_O) begin
`ifdef FC2_ARGMAX_EN
                  state             <= S_ARGMAX;
                  result_bram_ena   <= 1'b1;
                  result_bram_wea   <= 1'b1;
                  result_bram_addra <= RES_AW'(OUT_BASE + N_OUT);
`else
                  state       <= S_DONE;
                  fc_2_finish <= 1'b1;
`endif
               end else begin
                  state                   <= S_BIAS;
                  bias_weights_bram_ena   <= 1'b1;
                  bias_weights_bram_addra <= BW_AW'(B_BASE + int'(o) + 1);
               end
            end

`ifdef FC2_ARGMAX_EN
            S_ARGMAX: begin
               state           <= S_DONE;
               result_bram_ena <= 1'b0;
               result_bram_wea <= 1'b0;
               fc_2_finish     <= 1'b1;
            end
`endif

            S_DONE: begin
               if (!fc_2_en) begin
                  state                   <= S_IDLE;
                  fc_2_finish             <= 1'b0;
                  bias_weights_bram_addra <= '0;
                  result_bram_addra       <= '0;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_2.sv
// Purpose : self-checking bench for fc_2 (RD_LAT=2, FRAC_BITS=0) with behavioural BRAM models and a write scoreboard.
// Latency : expects finish 10*(501*3+2)+1 cycles after fc_2_en is sampled.
// Backpres: none; stimulus pushes expected result-BRAM writes, a monitor pops them on every write strobe.
module tb_fc_2;

   localparam int LAYER_CYC = 10 * (501 * 3 + 2) + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        fc_2_en;
   logic [7:0]  bias_weights_bram_douta;
   logic [7:0]  result_bram_douta;
   logic        bias_weights_bram_ena;
   logic [18:0] bias_weights_bram_addra;
   logic        result_bram_ena;
   logic        result_bram_wea;
   logic [14:0] result_bram_addra;
   logic [7:0]  result_bram_dina;
   logic        fc_2_finish;
   logic [3:0]  class_id;

   int checks   = 0;
   int failures = 0;
   int img      = 0;

   typedef struct {
      int addr;
      int dat;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;

   // Hand-computed scores for image 1 (inputs: 5 for i<10, 1 otherwise).
   logic [7:0] exp_b [0:9] = '{8'h80, 8'h7F, 8'hF9, 8'h64, 8'h32,
                               8'hD1, 8'h7F, 8'h32, 8'hEC, 8'h80};

   always #5 clk = ~clk;

   fc_2 #(
      .FRAC_BITS (0),
      .RD_LAT    (2)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .fc_2_en                 (fc_2_en),
      .bias_weights_bram_douta (bias_weights_bram_douta),
      .result_bram_douta       (result_bram_douta),
      .bias_weights_bram_ena   (bias_weights_bram_ena),
      .bias_weights_bram_addra (bias_weights_bram_addra),
      .result_bram_ena         (result_bram_ena),
      .result_bram_wea         (result_bram_wea),
      .result_bram_addra       (result_bram_addra),
      .result_bram_dina        (result_bram_dina),
      .fc_2_finish             (fc_2_finish),
      .class_id                (class_id)
   );

   // ---------------- memory images ----------------
   function automatic logic [7:0] w_of(input int o, input int i);
      if (img == 0) return 8'h01;
      case (o)
         0:       return 8'hFF;
         1:       return 8'h01;
         3:       return (i < 10) ? 8'h02 : 8'h00;
         4, 7:    return (i < 10) ? 8'h01 : 8'h00;
         5:       return (i < 10) ? 8'hFF : 8'h00;
         8:       return (i >= 10 && i < 110) ? 8'h01 : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] b_of(input int o);
      if (img == 0) return 8'(o);
      case (o)
         2:       return 8'hF9;
         5:       return 8'h03;
         6:       return 8'h7F;
         8:       return 8'h88;
         9:       return 8'h80;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] x_of(input int i);
      if (img == 0) return 8'h00;
      return (i < 10) ? 8'h05 : 8'h01;
   endfunction

   function automatic logic [7:0] bw_mem(input logic [18:0] a);
      int ai = int'(a);
      if (ai >= 436070 && ai < 436080) return b_of(ai - 436070);
      if (ai >= 431070 && ai < 436070) return w_of((ai - 431070) / 500, (ai - 431070) % 500);
      return 8'h5A;
   endfunction

   function automatic logic [7:0] rs_mem(input logic [14:0] a);
      int ai = int'(a);
      if (ai >= 18400 && ai < 18900) return x_of(ai - 18400);
      return 8'hA5;
   endfunction

   // Two-cycle read pipelines.
   logic [7:0] bw_p0 = 8'h00, bw_p1 = 8'h00, rs_p0 = 8'h00, rs_p1 = 8'h00;
   always @(posedge clk) begin
      if (bias_weights_bram_ena) bw_p0 <= bw_mem(bias_weights_bram_addra);
      bw_p1 <= bw_p0;
      if (result_bram_ena && !result_bram_wea) rs_p0 <= rs_mem(result_bram_addra);
      rs_p1 <= rs_p0;
   end
   assign bias_weights_bram_douta = bw_p1;
   assign result_bram_douta       = rs_p1;

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, want, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && result_bram_ena && result_bram_wea) begin
         chk("rd_wr_overlap", 32'(bias_weights_bram_ena), 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write",
                     result_bram_addra, result_bram_dina);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 32'(result_bram_addra), 32'(mon_e.addr));
            chk("wr_dat", 32'(result_bram_dina), 32'(mon_e.dat));
         end
      end
   end

   task automatic push_img(input int sel, input int n);
      wr_t w;
      for (int k = 0; k < n; k++) begin
         w.addr = 18900 + k;
         w.dat  = (sel == 0) ? k : int'(exp_b[k]);
         exp_q.push_back(w);
      end
   endtask

   task automatic wait_finish(input int budget, output int n);
      n = -1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (fc_2_finish) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, "_bw_ena"}, 32'(bias_weights_bram_ena), 32'd0);
      chk({nm, "_rs_ena"}, 32'(result_bram_ena), 32'd0);
      chk({nm, "_wea"}, 32'(result_bram_wea), 32'd0);
      chk({nm, "_finish"}, 32'(fc_2_finish), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst     = 1'b0;
      fc_2_en = 1'b0;
      repeat (3) @(negedge clk);
      chk_quiet("reset");
      chk("reset_bw_addr", 32'(bias_weights_bram_addra), 32'd0);
      chk("reset_rs_addr", 32'(result_bram_addra), 32'd0);
      chk("reset_dina", 32'(result_bram_dina), 32'd0);
      chk("reset_class", 32'(class_id), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_quiet("idle");

      // Run 1: weights 1, inputs 0, biases 0..9.
      img = 0;
      push_img(0, 10);
      fc_2_en = 1'b1;
      wait_finish(LAYER_CYC + 200, n);
      chk("run1_latency", 32'(n), 32'(LAYER_CYC));
      repeat (3) @(negedge clk);
      chk("run1_finish_hold", 32'(fc_2_finish), 32'd1);
      chk("run1_all_writes", 32'(exp_q.size()), 32'd0);
      chk("run1_class", 32'(class_id), 32'd0);
      fc_2_en = 1'b0;
      @(negedge clk);
      chk_quiet("run1_exit");

      // Run 2: mixed image, abort in the middle of neuron 5.
      img = 1;
      push_img(1, 5);
      fc_2_en = 1'b1;
      repeat (8200) @(negedge clk);
      chk("abort_in_n5", 32'(bias_weights_bram_addra >= 19'd433570 && bias_weights_bram_addra < 19'd434070), 32'd1);
      fc_2_en = 1'b0;
      @(negedge clk);
      chk_quiet("abort");
      repeat (20) @(negedge clk);
      chk("abort_writes", 32'(exp_q.size()), 32'd0);

      // Run 3: full rerun of the mixed image after the abort.
      push_img(1, 10);
      fc_2_en = 1'b1;
      wait_finish(LAYER_CYC + 200, n);
      chk("run3_latency", 32'(n), 32'(LAYER_CYC));
      repeat (2) @(negedge clk);
      chk("run3_all_writes", 32'(exp_q.size()), 32'd0);
      chk("run3_class", 32'(class_id), 32'd0);
      fc_2_en = 1'b0;
      @(negedge clk);
      chk_quiet("run3_exit");

      // Run 4: asynchronous reset in S_MAC of neuron 0, then full run.
      fc_2_en = 1'b1;
      repeat (300) @(negedge clk);
      chk("rst_pre_mac", 32'(result_bram_ena), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk_quiet("async_rst");
      chk("async_rst_bw_addr", 32'(bias_weights_bram_addra), 32'd0);
      chk("async_rst_rs_addr", 32'(result_bram_addra), 32'd0);
      @(negedge clk);
      chk("async_rst_writes", 32'(exp_q.size()), 32'd0);
      push_img(1, 10);
      rst = 1'b1;
      wait_finish(LAYER_CYC + 200, n);
      chk("run4_latency", 32'(n), 32'(LAYER_CYC));
      repeat (2) @(negedge clk);
      chk("run4_all_writes", 32'(exp_q.size()), 32'd0);
      fc_2_en = 1'b0;
      @(negedge clk);
      chk_quiet("run4_exit");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
